// File: rtl/xgriscv_sc.sv
// Single-cycle RV32I core: one instruction retires per rising clock edge.
// Instruction and data memories are on-chip. Both memories read combinationally.
module imem #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   rd
);
    logic [31:0] RAM [0:WORDS-1];

    assign rd = RAM[addr];
endmodule

module dmem #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);
    logic [31:0] RAM [0:WORDS-1];

    assign rd = RAM[addr];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) RAM[addr][8*i +: 8] <= wd[8*i +: 8];
        end
    end
endmodule

module regfile (
    input  logic        clk,
    input  logic        rstn,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] rf [0:31];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we && wa != 5'd0) begin
            rf[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : rf[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : rf[ra2];
endmodule

module xgriscv_sc #(
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [31:0] pc
);
    localparam int unsigned IAW = $clog2(IMEM_WORDS);
    localparam int unsigned DAW = $clog2(DMEM_WORDS);

    logic [31:0] instr, rs1v, rs2v, pc4, next_pc, wd, mem_addr, mem_rd, dm_wd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [3:0]  dm_be;
    logic [15:0] half;
    logic [7:0]  bval;
    logic        rf_we, take;
    logic        unused_bits;

    function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return alt ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return {31'b0, $signed(a) < $signed(b)};
            3'b011:  return {31'b0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    imem #(.WORDS(IMEM_WORDS), .AW(IAW)) U_imem (.addr(pc[IAW+1:2]), .rd(instr));

    regfile U_rf (
        .clk(clk), .rstn(rstn), .we(rf_we), .ra1(rs1), .ra2(rs2), .wa(rd),
        .wd(wd), .rd1(rs1v), .rd2(rs2v)
    );

    dmem #(.WORDS(DMEM_WORDS), .AW(DAW)) U_dmem (
        .clk(clk), .we(dm_be & {4{rstn}}), .addr(mem_addr[DAW+1:2]),
        .wd(dm_wd), .rd(mem_rd)
    );

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign pc4      = pc + 32'd4;
    assign mem_addr = rs1v + ((opcode == 7'b0100011) ? imm_s : imm_i);
    assign half     = mem_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    // High address bits fall outside the data memory and simply wrap.
    assign unused_bits = ^mem_addr[31:DAW+2];

    always_comb begin
        case (mem_addr[1:0])
            2'b00:   bval = mem_rd[7:0];
            2'b01:   bval = mem_rd[15:8];
            2'b10:   bval = mem_rd[23:16];
            default: bval = mem_rd[31:24];
        endcase
    end

    always_comb begin
        rf_we   = 1'b0;
        wd      = '0;
        next_pc = pc4;
        dm_be   = '0;
        dm_wd   = '0;
        take    = 1'b0;
        case (opcode)
            7'b0110111: begin rf_we = 1'b1; wd = imm_u; end
            7'b0010111: begin rf_we = 1'b1; wd = pc + imm_u; end
            7'b1101111: begin rf_we = 1'b1; wd = pc4; next_pc = pc + imm_j; end
            7'b1100111: begin
                if (f3 == 3'b000) begin
                    rf_we   = 1'b1;
                    wd      = pc4;
                    next_pc = (rs1v + imm_i) & ~32'd1;
                end
            end
            7'b1100011: begin
                case (f3)
                    3'b000:  take = (rs1v == rs2v);
                    3'b001:  take = (rs1v != rs2v);
                    3'b100:  take = ($signed(rs1v) < $signed(rs2v));
                    3'b101:  take = ($signed(rs1v) >= $signed(rs2v));
                    3'b110:  take = (rs1v < rs2v);
                    3'b111:  take = (rs1v >= rs2v);
                    default: take = 1'b0;
                endcase
                if (take) next_pc = pc + imm_b;
            end
            7'b0000011: begin
                rf_we = 1'b1;
                case (f3)
                    3'b000:  wd = {{24{bval[7]}}, bval};
                    3'b001:  wd = {{16{half[15]}}, half};
                    3'b010:  wd = mem_rd;
                    3'b100:  wd = {24'b0, bval};
                    3'b101:  wd = {16'b0, half};
                    default: rf_we = 1'b0;
                endcase
            end
            7'b0100011: begin
                case (f3)
                    3'b000: begin dm_be = 4'b0001 << mem_addr[1:0]; dm_wd = {4{rs2v[7:0]}}; end
                    3'b001: begin dm_be = mem_addr[1] ? 4'b1100 : 4'b0011; dm_wd = {2{rs2v[15:0]}}; end
                    3'b010: begin dm_be = 4'b1111; dm_wd = rs2v; end
                    default: ;
                endcase
            end
            7'b0010011: begin
                if (f3 == 3'b001)      rf_we = (f7 == 7'b0);
                else if (f3 == 3'b101) rf_we = (f7 == 7'b0) || (f7 == 7'b0100000);
                else                   rf_we = 1'b1;
                wd = alu(f3, (f3 == 3'b101) && instr[30], rs1v, imm_i);
            end
            7'b0110011: begin
                rf_we = (f7 == 7'b0) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                wd = alu(f3, instr[30], rs1v, rs2v);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) pc <= '0;
        else       pc <= next_pc;
    end
endmodule

// File: tb/tb_xgriscv_sc.sv
// Directed bench for xgriscv_sc: small hand-assembled programs, checked
// against hand-computed register, memory and pc values.
module tb_xgriscv_sc;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pc;
    int          tests = 0;
    int          fails = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    xgriscv_sc #(.IMEM_WORDS(1024), .DMEM_WORDS(1024)) dut (
        .clk(clk), .rstn(rstn), .pc(pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] i_t(input logic [31:0] op, rd, f3, rs1, imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] r_t(input logic [31:0] f7, rs2, rs1, f3, rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] s_t(input logic [31:0] f3, rs2, rs1, imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(input logic [31:0] f3, rs1, rs2, imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] j_t(input logic [31:0] rd, imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction
    function automatic logic [31:0] u_t(input logic [31:0] op, rd, imm20);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] xr(input int n);
        return dut.U_rf.rf[n];
    endfunction

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < 1024; i++) dut.U_imem.RAM[i] = w;
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        dut.U_imem.RAM[addr/4] = w;
    endtask

    // Two reset edges; on return pc has just been forced to 0 and rstn is high.
    task automatic do_reset;
        @(negedge clk) rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        fill(NOP);
        for (int i = 1; i < 32; i++) put(4*(i-1), i_t(7'h13, i, 0, 0, i + 100));
        do_reset;
        step(31);
        do_reset;
        tests++;
        if (pc !== 32'h0) begin
            fails++; $display("FAIL reset_pc: got %h expected 00000000", pc);
        end
        for (int r = 1; r < 32; r++) begin
            tests++;
            if (xr(r) !== 32'h0) begin
                fails++; $display("FAIL reset_x%0d: got %h expected 00000000", r, xr(r));
            end
        end
        for (int k = 1; k < 3; k++) begin
            step(1);
            tests++;
            if (pc !== 32'(4*k)) begin
                fails++; $display("FAIL release_pc%0d: got %h expected %h", k, pc, 32'(4*k));
            end
        end
    endtask

    task automatic test_reset_mid;
        fill(i_t(7'h13, 1, 0, 1, 1));
        do_reset;
        step(3);
        tests++;
        if (xr(1) !== 32'd3) begin
            fails++; $display("FAIL mid_run_x1: got %h expected 00000003", xr(1));
        end
        rstn = 1'b0;
        step(1);
        tests++;
        if (pc !== 32'h0 || xr(1) !== 32'h0) begin
            fails++; $display("FAIL mid_reset: got pc=%h x1=%h expected pc=0 x1=0", pc, xr(1));
        end
        rstn = 1'b1;
        step(1);
        tests++;
        if (pc !== 32'h4 || xr(1) !== 32'h1) begin
            fails++; $display("FAIL mid_restart: got pc=%h x1=%h expected pc=4 x1=1", pc, xr(1));
        end
    endtask

    task automatic test_alu;
        logic [31:0] ev [11];
        fill(NOP);
        put('h00, i_t(7'h13, 1, 0, 0, 5));
        put('h04, i_t(7'h13, 2, 0, 0, -3));
        put('h08, r_t(0, 2, 1, 0, 3));
        put('h0c, r_t(32, 1, 2, 0, 4));
        put('h10, r_t(32, 1, 2, 5, 5));
        put('h14, r_t(0, 2, 1, 3, 6));
        put('h18, r_t(0, 1, 2, 2, 7));
        put('h1c, i_t(7'h13, 8, 5, 2, 28));
        put('h20, i_t(7'h13, 9, 4, 1, -1));
        put('h24, u_t(7'h37, 10, 'h12345));
        put('h28, u_t(7'h17, 11, 1));
        put('h2c, i_t(7'h13, 12, 1, 1, 3));
        put('h30, r_t(0, 9, 2, 7, 13));
        ev = '{32'h2, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h1, 32'h1, 32'hF,
               32'hFFFFFFFA, 32'h12345000, 32'h00001028, 32'h28, 32'hFFFFFFF8};
        do_reset;
        step(13);
        tests++;
        if (pc !== 32'h34) begin
            fails++; $display("FAIL alu_pc: got %h expected 00000034", pc);
        end
        for (int i = 0; i < 11; i++) begin
            tests++;
            if (xr(i+3) !== ev[i]) begin
                fails++; $display("FAIL alu_x%0d: got %h expected %h", i+3, xr(i+3), ev[i]);
            end
        end
    endtask

    task automatic test_mem;
        logic [31:0] ev [11];
        fill(NOP);
        put('h00, i_t(7'h13, 1, 0, 0, 128));
        put('h04, u_t(7'h37, 2, 'h12345));
        put('h08, i_t(7'h13, 2, 0, 2, 'h687));
        put('h0c, s_t(2, 2, 1, 0));
        put('h10, i_t(7'h03, 3, 0, 1, 3));
        put('h14, i_t(7'h03, 4, 4, 1, 0));
        put('h18, i_t(7'h03, 5, 0, 1, 0));
        put('h1c, i_t(7'h03, 6, 1, 1, 0));
        put('h20, i_t(7'h03, 7, 5, 1, 2));
        put('h24, s_t(1, 0, 1, 2));
        put('h28, i_t(7'h03, 8, 2, 1, 0));
        put('h2c, s_t(0, 2, 1, 1));
        put('h30, i_t(7'h03, 9, 2, 1, 0));
        put('h34, i_t(7'h03, 10, 1, 1, 0));
        put('h38, u_t(7'h37, 11, 1));
        put('h3c, r_t(0, 1, 11, 0, 11));
        put('h40, i_t(7'h03, 12, 2, 11, 0));
        put('h44, i_t(7'h03, 13, 2, 1, 2));
        ev = '{32'h12, 32'h87, 32'hFFFFFF87, 32'h5687, 32'h1234, 32'h5687,
               32'h8787, 32'hFFFF8787, 32'h1080, 32'h8787, 32'h8787};
        do_reset;
        step(18);
        tests++;
        if (pc !== 32'h48) begin
            fails++; $display("FAIL mem_pc: got %h expected 00000048", pc);
        end
        for (int i = 0; i < 11; i++) begin
            tests++;
            if (xr(i+3) !== ev[i]) begin
                fails++; $display("FAIL mem_x%0d: got %h expected %h", i+3, xr(i+3), ev[i]);
            end
        end
        // Data memory must survive a reset.
        fill(NOP);
        put('h00, i_t(7'h03, 1, 2, 0, 128));
        do_reset;
        step(1);
        tests++;
        if (xr(1) !== 32'h8787) begin
            fails++; $display("FAIL mem_keep: got %h expected 00008787", xr(1));
        end
    endtask

    task automatic test_branch;
        logic [31:0] ep [15];
        fill(NOP);
        put('h00, i_t(7'h13, 5, 0, 0, 1));
        put('h04, i_t(7'h13, 6, 0, 0, 1));
        put('h08, i_t(7'h13, 7, 0, 0, 2));
        put('h10, b_t(0, 5, 6, 8));
        put('h14, i_t(7'h67, 0, 0, 1, 1));
        put('h18, i_t(7'h13, 6, 0, 6, 1));
        put('h1c, i_t(7'h13, 8, 0, 0, -1));
        put('h20, j_t(1, -16));
        put('h24, b_t(1, 5, 6, 8));
        put('h2c, b_t(5, 5, 6, -8));
        put('h30, b_t(4, 8, 5, 8));
        put('h38, b_t(6, 8, 5, 8));
        put('h3c, b_t(7, 8, 5, 8));
        ep = '{32'h04, 32'h08, 32'h0c, 32'h10, 32'h18, 32'h1c, 32'h20, 32'h10,
               32'h14, 32'h24, 32'h2c, 32'h30, 32'h38, 32'h3c, 32'h44};
        do_reset;
        for (int i = 0; i < 15; i++) begin
            step(1);
            tests++;
            if (pc !== ep[i]) begin
                fails++; $display("FAIL branch_step%0d: got pc=%h expected %h", i, pc, ep[i]);
            end
            if (i == 7) begin
                tests++;
                if (xr(1) !== 32'h24) begin
                    fails++; $display("FAIL jal_link: got %h expected 00000024", xr(1));
                end
            end
        end
    endtask

    task automatic test_x0_unknown;
        logic [31:0] ep [8];
        fill(NOP);
        put('h00, i_t(7'h13, 0, 0, 0, 7));
        put('h04, i_t(7'h13, 9, 0, 0, 3));
        put('h08, r_t(0, 0, 9, 0, 9));
        put('h0c, 32'hFFFFFFFF);
        put('h10, 32'h00000073);
        put('h14, 32'h0000000F);
        put('h18, r_t(1, 9, 9, 0, 10));
        put('h1c, i_t(7'h13, 11, 1, 9, 'h401));
        ep = '{32'h04, 32'h08, 32'h0c, 32'h10, 32'h14, 32'h18, 32'h1c, 32'h20};
        do_reset;
        for (int i = 0; i < 8; i++) begin
            step(1);
            tests++;
            if (pc !== ep[i]) begin
                fails++; $display("FAIL nop_step%0d: got pc=%h expected %h", i, pc, ep[i]);
            end
        end
        tests++;
        if (xr(9) !== 32'd3) begin
            fails++; $display("FAIL x0_reads_zero: got x9=%h expected 00000003", xr(9));
        end
        tests++;
        if (xr(31) !== 32'h0 || xr(10) !== 32'h0 || xr(11) !== 32'h0) begin
            fails++; $display("FAIL unknown_no_write: got x31=%h x10=%h x11=%h expected 0",
                              xr(31), xr(10), xr(11));
        end
    endtask

    task automatic test_run_to_addr;
        int n;
        fill(NOP);
        put('h00, i_t(7'h13, 1, 0, 0, 1));
        for (int a = 'h04; a < 'h1c; a += 4) put(a, i_t(7'h13, 1, 0, 1, 1));
        put('h1c, j_t(0, 0));
        do_reset;
        n = 1;  // the last reset edge, which puts pc at 0, counts as the first
        while (pc !== 32'h1c && n < 20) begin
            step(1);
            n++;
        end
        tests++;
        if (n !== 8) begin
            fails++; $display("FAIL run_to_1c: got %0d edges expected 8", n);
        end
        tests++;
        if (xr(1) !== 32'd7) begin
            fails++; $display("FAIL run_x1: got %h expected 00000007", xr(1));
        end
        step(3);
        tests++;
        if (pc !== 32'h1c) begin
            fails++; $display("FAIL self_loop: got %h expected 0000001c", pc);
        end
    endtask

    initial begin
        test_reset;
        test_reset_mid;
        test_alu;
        test_mem;
        test_branch;
        test_x0_unknown;
        test_run_to_addr;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
